// File: rtl/control_sequencer.sv
// Hardwired Moore control unit for the single-bus datapath. It sequences fetch (T0-T2,
// with T1W memory wait states) and execute (T3-T5) for three-register ALU instructions.
module control_sequencer (
  input  logic        clk,
  input  logic        clear,
  input  logic [31:0] IR,
  input  logic        mem_ready,
  input  logic        stop,
  output logic        PCout,
  output logic        Zlowout,
  output logic        MDRout,
  output logic        MARin,
  output logic        Zin,
  output logic        PCin,
  output logic        MDRin,
  output logic        IRin,
  output logic        Yin,
  output logic        IncPC,
  output logic        Read,
  output logic        Gra,
  output logic        Grb,
  output logic        Grc,
  output logic        Rin,
  output logic        Rout,
  output logic [4:0]  Operator,
  output logic        run,
  output logic        illegal,
  output logic [15:0] instr_count
);

  typedef enum logic [3:0] {
    S_RST, S_T0, S_T1, S_T1W, S_T2, S_T3, S_T4, S_T5, S_HALT
  } state_t;

  localparam logic [4:0] OP_ALU_MAX = 5'd12;
  localparam logic [4:0] OP_HALT    = 5'd26;
  localparam logic [4:0] OP_NOP     = 5'd27;

  state_t      state, state_nxt;
  logic        stop_pending;
  logic        retire;
  logic        halt_req;
  logic [4:0]  opcode;
  logic        op_alu, op_nop, op_halt, op_ill;
  logic        unused_ir;

  // Register fields are consumed by the datapath's select logic, not here.
  assign unused_ir = ^IR[26:0];

  assign opcode  = IR[31:27];
  assign op_alu  = (opcode <= OP_ALU_MAX);
  assign op_nop  = (opcode == OP_NOP);
  assign op_halt = (opcode == OP_HALT);
  assign op_ill  = !(op_alu || op_nop || op_halt);

  // A stop arriving in the retire cycle itself must still halt at that edge.
  assign halt_req = stop_pending | stop;

  always_ff @(posedge clk) begin
    if (clear) begin
      state        <= S_RST;
      stop_pending <= 1'b0;
      instr_count  <= 16'd0;
    end else begin
      state <= state_nxt;
      if (stop)   stop_pending <= 1'b1;
      if (retire) instr_count  <= instr_count + 16'd1;
    end
  end

  always_comb begin
    {PCout, Zlowout, MDRout, MARin, Zin, PCin, MDRin, IRin,
     Yin, IncPC, Read, Gra, Grb, Grc, Rin, Rout} = '0;
    Operator  = 5'd0;
    run       = 1'b1;
    illegal   = 1'b0;
    retire    = 1'b0;
    state_nxt = state;
    case (state)
      S_RST: begin
        run       = 1'b0;
        state_nxt = S_T0;
      end
      S_T0: begin
        PCout     = 1'b1;
        MARin     = 1'b1;
        IncPC     = 1'b1;
        Zin       = 1'b1;
        state_nxt = S_T1;
      end
      S_T1: begin
        Zlowout   = 1'b1;
        PCin      = 1'b1;
        Read      = 1'b1;
        MDRin     = 1'b1;
        state_nxt = mem_ready ? S_T2 : S_T1W;
      end
      S_T1W: begin
        // Hold the read open; PC was already updated in T1.
        Read  = 1'b1;
        MDRin = 1'b1;
        if (mem_ready) state_nxt = S_T2;
      end
      S_T2: begin
        MDRout    = 1'b1;
        IRin      = 1'b1;
        state_nxt = S_T3;
      end
      S_T3: begin
        if (op_alu) begin
          Grb       = 1'b1;
          Rout      = 1'b1;
          Yin       = 1'b1;
          state_nxt = S_T4;
        end else if (op_halt) begin
          state_nxt = S_HALT;
        end else begin
          illegal   = op_ill;
          retire    = 1'b1;
          state_nxt = halt_req ? S_HALT : S_T0;
        end
      end
      S_T4: begin
        Grc       = 1'b1;
        Rout      = 1'b1;
        Zin       = 1'b1;
        Operator  = opcode;
        state_nxt = S_T5;
      end
      S_T5: begin
        Zlowout   = 1'b1;
        Gra       = 1'b1;
        Rin       = 1'b1;
        retire    = 1'b1;
        state_nxt = halt_req ? S_HALT : S_T0;
      end
      S_HALT: begin
        run = 1'b0;
      end
      default: begin
        run       = 1'b0;
        state_nxt = S_RST;
      end
    endcase
  end

endmodule
